// File: rtl/echo_initiator_pkg.sv
// Shared definitions for the echo initiator/responder pair: state encoding,
// payload widths and the sequence-replication pattern.
package echo_initiator_pkg;

  localparam int unsigned SEQ_W      = 16;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned DATA_W_DEF = 192;
  localparam int unsigned PAT_MAX_W  = 1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } echo_state_e;

  // Replicate a 16-bit word across the widest supported payload; callers narrow it.
  function automatic logic [PAT_MAX_W-1:0] rep_pattern(input logic [SEQ_W-1:0] word);
    logic [PAT_MAX_W-1:0] r;
    for (int unsigned i = 0; i < PAT_MAX_W / SEQ_W; i++) begin
      r[i*SEQ_W +: SEQ_W] = word;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
    return (x == '1) ? x : x + CNT_W'(1);
  endfunction

endpackage

// File: rtl/echo_initiator_if.sv
// Request (say) and echoed indication (heard) channels between initiator and responder.
interface echo_initiator_if #(
  parameter int unsigned DATA_W = echo_initiator_pkg::DATA_W_DEF
);
  logic              say__ENA;
  logic              say__RDY;
  logic [DATA_W-1:0] say_meth;
  logic [DATA_W-1:0] say_v;
  logic              heard__ENA;
  logic              heard__RDY;
  logic [DATA_W-1:0] heard_meth;
  logic [DATA_W-1:0] heard_v;

  modport master (
    output say__ENA, say_meth, say_v, heard__RDY,
    input  say__RDY, heard__ENA, heard_meth, heard_v
  );

  modport slave (
    input  say__ENA, say_meth, say_v, heard__RDY,
    output say__RDY, heard__ENA, heard_meth, heard_v
  );
endinterface

// File: rtl/echo_pattern_gen.sv
// Maps a sequence number to its request payload pair (word, inverted word), replicated.
module echo_pattern_gen
  import echo_initiator_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic [SEQ_W-1:0]  seq,
  output logic [DATA_W-1:0] meth,
  output logic [DATA_W-1:0] v
);

  assign meth = DATA_W'(rep_pattern(seq));
  assign v    = DATA_W'(rep_pattern(~seq));

endmodule

// File: rtl/echo_initiator.sv
// Echo initiator: issues a run of sequenced requests, bounded by an outstanding
// window, and counts echoed indications that mismatch or arrive unexpectedly.
module echo_initiator
  import echo_initiator_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned DATA_W          = DATA_W_DEF
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start__ENA,
  input  logic [SEQ_W-1:0]     start_count,
  output logic                 start__RDY,
  output logic                 done,
  output logic [CNT_W-1:0]     err_count,
  echo_initiator_if.master     bus
);

  localparam int unsigned OUT_W = 4;

  echo_state_e       state_q, state_d;
  logic [SEQ_W-1:0]  total_q, total_d;
  logic [SEQ_W-1:0]  tx_q, tx_d;
  logic [SEQ_W-1:0]  rx_q, rx_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [CNT_W-1:0]  err_d;
  logic              say_ena_d;
  logic              tx_fire, rx_fire, rx_expected, rx_bad;
  logic [DATA_W-1:0] exp_meth, exp_v;

  echo_pattern_gen #(.DATA_W(DATA_W)) u_tx_pat (
    .seq  (tx_q),
    .meth (bus.say_meth),
    .v    (bus.say_v)
  );

  echo_pattern_gen #(.DATA_W(DATA_W)) u_rx_pat (
    .seq  (rx_q),
    .meth (exp_meth),
    .v    (exp_v)
  );

  // Next-state, counters and next values of the registered handshake outputs.
  always_comb begin
    state_d     = state_q;
    total_d     = total_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    out_d       = out_q;
    err_d       = err_count;
    tx_fire     = bus.say__ENA && bus.say__RDY;
    rx_fire     = bus.heard__RDY && bus.heard__ENA;
    rx_expected = (out_q != '0);
    rx_bad      = (bus.heard_meth != exp_meth) || (bus.heard_v != exp_v);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start__ENA) begin
          total_d = start_count;
          tx_d    = '0;
          rx_d    = '0;
          out_d   = '0;
          err_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (tx_fire) tx_d = tx_q + SEQ_W'(1);
        if (rx_fire && rx_expected) rx_d = rx_q + SEQ_W'(1);
        if (rx_fire && (!rx_expected || rx_bad)) err_d = sat_inc(err_count);
        out_d = out_q + OUT_W'(tx_fire) - OUT_W'(rx_fire && rx_expected);
        // An empty run passes straight through to DONE without visiting DRAIN.
        if ((tx_d == total_q) && (rx_d == total_q)) state_d = ST_DONE;
        else if (tx_d == total_q)                   state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase

    say_ena_d = (state_d == ST_RUN) && (tx_d < total_d) &&
                (out_d < OUT_W'(MAX_OUTSTANDING));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q        <= ST_IDLE;
      total_q        <= '0;
      tx_q           <= '0;
      rx_q           <= '0;
      out_q          <= '0;
      err_count      <= '0;
      bus.say__ENA   <= 1'b0;
      bus.heard__RDY <= 1'b0;
      start__RDY     <= 1'b1;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      total_q        <= total_d;
      tx_q           <= tx_d;
      rx_q           <= rx_d;
      out_q          <= out_d;
      err_count      <= err_d;
      bus.say__ENA   <= say_ena_d;
      bus.heard__RDY <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
      start__RDY     <= (state_d == ST_IDLE) || (state_d == ST_DONE);
      done           <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_echo_initiator.sv
// Directed bench for echo_initiator: a count-based run model checked every cycle,
// an echo responder with configurable latency, and scenario-level literal checks.
module tb_echo_initiator;

  localparam int unsigned DW    = 192;
  localparam int unsigned MAXO  = 2;
  localparam int unsigned LANES = DW / 16;

  logic        CLK         = 1'b0;
  logic        nRST        = 1'b1;
  logic        start__ENA  = 1'b0;
  logic [15:0] start_count = 16'd0;
  logic        start__RDY;
  logic        done;
  logic [15:0] err_count;

  echo_initiator_if #(.DATA_W(DW)) bus ();

  echo_initiator #(.MAX_OUTSTANDING(MAXO), .DATA_W(DW)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .start__ENA  (start__ENA),
    .start_count (start_count),
    .start__RDY  (start__RDY),
    .done        (done),
    .err_count   (err_count),
    .bus         (bus)
  );

  initial forever #5 CLK = ~CLK;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [15:0] s);
    return {LANES{s}};
  endfunction

  // Run model: counts of sent/heard requests, no notion of internal states.
  bit          m_active   = 1'b0;
  bit          m_finished = 1'b0;
  int          m_total, m_sent, m_heard, m_errs;
  bit          x_ena, x_fire;
  logic [15:0] hs, ss;

  typedef struct {
    logic [DW-1:0] meth;
    logic [DW-1:0] v;
    int            due;
  } echo_t;

  echo_t       echo_q[$];
  echo_t       e;
  logic [15:0] xfer_q[$];
  int          cyc         = 0;
  int          n_echo      = 0;
  int          inject_done = 0;

  int resp_lat   = 2;
  bit resp_en    = 1'b1;
  int corrupt_at = -1;
  int inject_cnt = 0;

  // Responder drives after each rising edge; model compare/advance on falling edge.
  initial begin
    m_total = 0; m_sent = 0; m_heard = 0; m_errs = 0;
    forever begin
      @(posedge CLK); #2;
      bus.heard__ENA = 1'b0;
      bus.heard_meth = '0;
      bus.heard_v    = '0;
      if (nRST) begin
        if (inject_done < inject_cnt) begin
          inject_done++;
          bus.heard__ENA = 1'b1;
          bus.heard_meth = pat(16'hBEEF);
          bus.heard_v    = pat(16'h1234);
        end else if (resp_en && echo_q.size() > 0 && echo_q[0].due <= cyc) begin
          e = echo_q.pop_front();
          bus.heard__ENA = 1'b1;
          bus.heard_meth = e.meth;
          bus.heard_v    = (n_echo == corrupt_at) ? (e.v ^ DW'(1)) : e.v;
          n_echo++;
        end
      end

      @(negedge CLK);
      if (!nRST) begin
        m_active = 1'b0; m_finished = 1'b0;
        m_total = 0; m_sent = 0; m_heard = 0; m_errs = 0;
        echo_q.delete();
      end
      x_ena = m_active && (m_sent < m_total) && ((m_sent - m_heard) < int'(MAXO));
      ss = 16'(m_sent);
      chk("start_rdy", DW'(start__RDY), DW'(!m_active));
      chk("heard_rdy", DW'(bus.heard__RDY), DW'(m_active));
      chk("done", DW'(done), DW'(m_finished));
      chk("err_count", DW'(err_count), DW'(m_errs));
      chk("say_ena", DW'(bus.say__ENA), DW'(x_ena));
      if (x_ena) begin
        chk("say_meth", bus.say_meth, pat(ss));
        chk("say_v", bus.say_v, pat(~ss));
      end

      if (nRST) begin
        if (bus.say__ENA && bus.say__RDY) begin
          echo_q.push_back('{meth: bus.say_meth, v: bus.say_v, due: cyc + resp_lat});
          xfer_q.push_back(bus.say_meth[15:0]);
        end
        if (!m_active) begin
          if (start__ENA) begin
            m_active = 1'b1; m_finished = 1'b0;
            m_total = int'(start_count); m_sent = 0; m_heard = 0; m_errs = 0;
          end
        end else begin
          x_fire = x_ena && bus.say__RDY;
          if (bus.heard__ENA) begin
            if (m_sent > m_heard) begin
              hs = 16'(m_heard);
              if (bus.heard_meth !== pat(hs) || bus.heard_v !== pat(~hs)) begin
                if (m_errs < 65535) m_errs++;
              end
              m_heard++;
            end else if (m_errs < 65535) begin
              m_errs++;
            end
          end
          if (x_fire) m_sent++;
          if (m_sent == m_total && m_heard == m_total) begin
            m_active = 1'b0; m_finished = 1'b1;
          end
        end
      end
      cyc++;
    end
  end

  task automatic do_start(input logic [15:0] n);
    @(posedge CLK); #1;
    start__ENA  = 1'b1;
    start_count = n;
    @(posedge CLK); #1;
    start__ENA  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge CLK);
      k++;
    end
    chk({name, "_done"}, DW'(done), DW'(1));
  endtask

  int xb, ne;

  initial begin
    bus.say__RDY = 1'b1;
    #1 nRST = 1'b0;
    repeat (3) @(posedge CLK);
    #3;
    chk("rst_start_rdy", DW'(start__RDY), DW'(1));
    chk("rst_say_ena", DW'(bus.say__ENA), DW'(0));
    chk("rst_heard_rdy", DW'(bus.heard__RDY), DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_err", DW'(err_count), DW'(0));
    @(posedge CLK); #1 nRST = 1'b1;

    // Four requests, full-rate ready, two-cycle echo.
    xb = xfer_q.size();
    do_start(16'd4);
    wait_done("s1", 50);
    chk("s1_xfers", DW'(xfer_q.size() - xb), DW'(4));
    for (int i = 0; i < 4; i++) chk("s1_word", DW'(xfer_q[xb+i]), DW'(i));
    chk("s1_err", DW'(err_count), DW'(0));

    // Ready held low for five cycles after the first request appears.
    @(posedge CLK); #1 bus.say__RDY = 1'b0;
    xb = xfer_q.size();
    do_start(16'd3);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk("s2_hold_ena", DW'(bus.say__ENA), DW'(1));
      chk("s2_hold_meth", bus.say_meth, '0);
      chk("s2_hold_v", bus.say_v, '1);
    end
    @(posedge CLK); #1 bus.say__RDY = 1'b1;
    wait_done("s2", 60);
    chk("s2_xfers", DW'(xfer_q.size() - xb), DW'(3));
    for (int i = 0; i < 3; i++) chk("s2_word", DW'(xfer_q[xb+i]), DW'(i));
    chk("s2_err", DW'(err_count), DW'(0));

    // Responder withholds echoes: the window caps issue at two.
    @(posedge CLK); #1 resp_en = 1'b0;
    xb = xfer_q.size();
    do_start(16'd4);
    repeat (6) @(negedge CLK);
    chk("s3_xfers_held", DW'(xfer_q.size() - xb), DW'(2));
    chk("s3_ena_low", DW'(bus.say__ENA), DW'(0));
    @(posedge CLK); #1 resp_en = 1'b1;
    wait_done("s3", 60);
    chk("s3_xfers", DW'(xfer_q.size() - xb), DW'(4));
    chk("s3_err", DW'(err_count), DW'(0));

    // Second echo corrupted in bit 0 of the B field.
    ne = n_echo;
    corrupt_at = n_echo + 1;
    do_start(16'd4);
    wait_done("s4", 60);
    chk("s4_err", DW'(err_count), DW'(1));
    chk("s4_model_err", DW'(m_errs), DW'(1));
    chk("s4_echoes", DW'(n_echo - ne), DW'(4));
    corrupt_at = -1;
    @(negedge CLK);
    chk("s4_err_hold", DW'(err_count), DW'(1));

    // Stray indication in IDLE, then an empty run.
    @(posedge CLK); #1 nRST = 1'b0;
    @(posedge CLK); #1 nRST = 1'b1;
    inject_cnt++;
    @(negedge CLK);
    chk("s5_idle_heard_rdy", DW'(bus.heard__RDY), DW'(0));
    chk("s5_idle_err", DW'(err_count), DW'(0));
    do_start(16'd0);
    @(negedge CLK);
    chk("s5_done_early", DW'(done), DW'(0));
    @(negedge CLK);
    chk("s5_done", DW'(done), DW'(1));
    chk("s5_err", DW'(err_count), DW'(0));

    // Reset with one request outstanding, then a fresh two-request run.
    @(posedge CLK); #1;
    resp_en = 1'b0;
    bus.say__RDY = 1'b0;
    xb = xfer_q.size();
    do_start(16'd2);
    bus.say__RDY = 1'b1;
    @(posedge CLK); #1 bus.say__RDY = 1'b0;
    @(negedge CLK);
    chk("s6_one_xfer", DW'(xfer_q.size() - xb), DW'(1));
    @(posedge CLK); #1 nRST = 1'b0;
    #2;
    chk("s6_rst_start_rdy", DW'(start__RDY), DW'(1));
    chk("s6_rst_say_ena", DW'(bus.say__ENA), DW'(0));
    chk("s6_rst_heard_rdy", DW'(bus.heard__RDY), DW'(0));
    chk("s6_rst_done", DW'(done), DW'(0));
    chk("s6_rst_err", DW'(err_count), DW'(0));
    chk("s6_rst_meth", bus.say_meth, '0);
    @(posedge CLK); #1;
    nRST = 1'b1;
    resp_en = 1'b1;
    bus.say__RDY = 1'b1;
    xb = xfer_q.size();
    do_start(16'd2);
    wait_done("s6", 60);
    chk("s6_xfers", DW'(xfer_q.size() - xb), DW'(2));
    for (int i = 0; i < 2; i++) chk("s6_word", DW'(xfer_q[xb+i]), DW'(i));
    chk("s6_err", DW'(err_count), DW'(0));

    repeat (2) @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached with %0d vectors applied", n_vec);
    $fatal(1, "bench time limit reached");
  end

endmodule
